// File: rtl/dwell_timer.sv
// Dwell timer: counts a loaded number of ticks (PRESCALE clk cycles each) down to zero and pulses expired.
// Optional feature macro DWELL_TIMER_HOLD_EN adds a hold input that freezes the countdown while high.
module dwell_timer #(
    parameter int unsigned TW       = 19,
    parameter int unsigned PRESCALE = 50000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] t_in,
`ifdef DWELL_TIMER_HOLD_EN
    input  logic          hold,
`endif
    output logic          busy,
    output logic          expired,
    output logic [TW-1:0] remaining
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_next;
    logic [TW-1:0] remaining_next;
    logic          expired_next;
    logic          busy_next;
    logic          frozen;

`ifdef DWELL_TIMER_HOLD_EN
    assign frozen = hold;
`else
    assign frozen = 1'b0;
`endif

    // State, prescaler and all outputs are registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pre       <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= state_next;
            pre       <= pre_next;
            remaining <= remaining_next;
            busy      <= busy_next;
            expired   <= expired_next;
        end
    end

    // Load beats hold and beats a coinciding terminal decrement.
    always_comb begin
        state_next     = state;
        pre_next       = pre;
        remaining_next = remaining;
        expired_next   = 1'b0;
        if (load) begin
            pre_next = '0;
            if (t_in != '0) begin
                state_next     = RUN;
                remaining_next = t_in;
            end else begin
                state_next     = IDLE;
                remaining_next = '0;
                expired_next   = 1'b1;
            end
        end else if (state == RUN && !frozen) begin
            if (pre == PRE_LAST) begin
                pre_next = '0;
                if (remaining != '0) begin
                    remaining_next = remaining - TW'(1);
                end
                if (remaining <= TW'(1)) begin
                    state_next   = IDLE;
                    expired_next = 1'b1;
                end
            end else begin
                pre_next = pre + PW'(1);
            end
        end
        busy_next = (state_next == RUN);
    end

endmodule

// File: tb/tb_dwell_timer.sv
// Directed bench for dwell_timer with PRESCALE=4, TW=19; define DWELL_TIMER_HOLD_EN to cover hold.
module tb_dwell_timer;

    localparam int unsigned TW = 19;
    localparam int unsigned PRESCALE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [TW-1:0] t_in;
`ifdef DWELL_TIMER_HOLD_EN
    logic          hold;
`endif
    logic          busy;
    logic          expired;
    logic [TW-1:0] remaining;

    int total = 0;
    int passed = 0;
    int exp_seen;

    always #5 clk = ~clk;

    dwell_timer #(.TW(TW), .PRESCALE(PRESCALE)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .t_in      (t_in),
`ifdef DWELL_TIMER_HOLD_EN
        .hold      (hold),
`endif
        .busy      (busy),
        .expired   (expired),
        .remaining (remaining)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) passed++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, req);
    endtask

    task automatic check_out(input string tag, input logic b, input logic e, input logic [31:0] r);
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".expired"}, 32'(expired), 32'(e));
        check({tag, ".remaining"}, 32'(remaining), r);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; t_in = '0;
`ifdef DWELL_TIMER_HOLD_EN
        hold = 1'b0;
`endif
        tick(); tick();
        check_out("reset", 1'b0, 1'b0, 0);
        rst = 1'b0;
        tick();

        // t_in=3: steps at E4/E8/E12, expired right after E12
        load = 1'b1; t_in = 19'd3; tick(); load = 1'b0;
        check_out("t3.e0", 1'b1, 1'b0, 3);
        repeat (3) tick();
        check("t3.e3.rem", 32'(remaining), 3);
        tick(); check("t3.e4.rem", 32'(remaining), 2);
        repeat (4) tick(); check("t3.e8.rem", 32'(remaining), 1);
        repeat (3) tick(); check_out("t3.e11", 1'b1, 1'b0, 1);
        tick(); check_out("t3.e12", 1'b0, 1'b1, 0);
        tick(); check_out("t3.e13", 1'b0, 1'b0, 0);
        repeat (3) tick(); check_out("t3.idle", 1'b0, 1'b0, 0);

        // zero-length dwell
        load = 1'b1; t_in = '0; tick(); load = 1'b0;
        check_out("t0.e0", 1'b0, 1'b1, 0);
        tick(); check_out("t0.e1", 1'b0, 1'b0, 0);

        // restart during RUN
        load = 1'b1; t_in = 19'd5; tick(); load = 1'b0;
        repeat (5) tick();
        check("rl.e5.rem", 32'(remaining), 4);
        load = 1'b1; t_in = 19'd2; tick(); load = 1'b0;
        check_out("rl.e6", 1'b1, 1'b0, 2);
        repeat (7) tick(); check_out("rl.e13", 1'b1, 1'b0, 1);
        tick(); check_out("rl.e14", 1'b0, 1'b1, 0);
        exp_seen = 0;
        repeat (6) begin tick(); if (expired) exp_seen++; end
        check("rl.no_old_expiry", 32'(exp_seen), 0);

        // load on the terminal edge wins
        load = 1'b1; t_in = 19'd1; tick(); load = 1'b0;
        repeat (3) tick();
        load = 1'b1; t_in = 19'd7; tick(); load = 1'b0;
        check_out("term.e4", 1'b1, 1'b0, 7);
        tick(); check("term.e5.expired", 32'(expired), 0);

        // reset mid-countdown, with a concurrent load that must lose
        load = 1'b1; t_in = 19'd4; tick(); load = 1'b0;
        repeat (4) tick();
        check("rst.e4.rem", 32'(remaining), 3);
        rst = 1'b1; load = 1'b1; t_in = 19'd9; tick();
        check_out("rst.e5", 1'b0, 1'b0, 0);
        rst = 1'b0; load = 1'b0;
        exp_seen = 0;
        repeat (40) begin tick(); if (expired || busy) exp_seen++; end
        check("rst.quiet40", 32'(exp_seen), 0);

        // first edge after reset release honours load
        rst = 1'b1; tick();
        rst = 1'b0; load = 1'b1; t_in = 19'd2; tick(); load = 1'b0;
        check_out("post_rst.load", 1'b1, 1'b0, 2);
        repeat (8) tick();
        check_out("post_rst.e8", 1'b0, 1'b1, 0);
        tick();

`ifdef DWELL_TIMER_HOLD_EN
        // hold sampled on edges 2..6 defers expiry from E8 to E13
        load = 1'b1; t_in = 19'd2; tick(); load = 1'b0;
        tick();
        hold = 1'b1;
        repeat (5) begin tick(); check_out("hold.frozen", 1'b1, 1'b0, 2); end
        hold = 1'b0;
        repeat (6) tick(); check_out("hold.e12", 1'b1, 1'b0, 1);
        tick(); check_out("hold.e13", 1'b0, 1'b1, 0);
        tick(); check("hold.e14.expired", 32'(expired), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running required finished");
        $fatal(1, "timeout");
    end

endmodule
